// File: rtl/c7b_trace_pkg.sv
// Shared types and widths for the commit-trace writer.
package c7b_trace_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DROP_W  = 16;

    typedef enum logic {
        TR_RUN,
        TR_FROZEN
    } tr_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic               wen;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/c7b_commit_trace_if.sv
// Trace read channel: head record plus valid/ready handshake.
interface c7b_commit_trace_if #(
    parameter int unsigned SEQ_W = 16
);
    import c7b_trace_pkg::*;

    logic               trace_valid;
    logic               trace_ready;
    logic [PC_W-1:0]    trace_pc;
    logic               trace_wen;
    logic [RADDR_W-1:0] trace_waddr;
    logic [DATA_W-1:0]  trace_wdata;
    logic [SEQ_W-1:0]   trace_seq;

    modport master (
        output trace_valid, trace_pc, trace_wen, trace_waddr, trace_wdata, trace_seq,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_pc, trace_wen, trace_waddr, trace_wdata, trace_seq,
        output trace_ready
    );

endinterface

// File: rtl/c7b_trace_fifo.sv
// Generic synchronous FIFO; read data is the registered head entry (no bypass).
module c7b_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop, wipe;

    assign wipe    = reset | flush;
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (wipe) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !wipe) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/c7b_commit_trace.sv
// Retirement trace writer: forms records, numbers them, buffers and drains them,
// and freezes capture on a PC match.
module c7b_commit_trace
    import c7b_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQ_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [PC_W-1:0]    wb_pc,
    input  logic               wb_rf_wen,
    input  logic [RADDR_W-1:0] wb_rf_waddr,
    input  logic [DATA_W-1:0]  wb_rf_wdata,
    input  logic               match_en,
    input  logic [PC_W-1:0]    match_pc,
    input  logic               trace_clear,
    c7b_commit_trace_if.master tr,
    output logic               trace_full,
    output logic               trace_frozen,
    output logic               trace_ovf,
    output logic [DROP_W-1:0]  drop_cnt
);
    localparam int unsigned ENT_W = SEQ_W + REC_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    tr_state_e          state_q, state_d;
    logic [SEQ_W-1:0]   seq_q;
    logic [DROP_W-1:0]  drop_cnt_q;
    logic               ovf_q;

    trace_rec_t         wb_rec, head_rec;
    logic [SEQ_W-1:0]   head_seq;
    logic [ENT_W-1:0]   head_raw;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic               run, push, pop, drop, match_hit;

    assign run       = (state_q == TR_RUN);
    assign pop       = tr.trace_valid & tr.trace_ready;
    assign push      = wb_valid & run & (~fifo_full | pop);
    assign drop      = wb_valid & run & fifo_full & ~pop;
    assign match_hit = wb_valid & match_en & (wb_pc == match_pc);

    // r0 writes are kept for address/data visibility but never flagged as writes.
    always_comb begin
        wb_rec       = '0;
        wb_rec.pc    = wb_pc;
        wb_rec.wen   = wb_rf_wen & (wb_rf_waddr != '0);
        wb_rec.waddr = wb_rf_waddr;
        wb_rec.wdata = wb_rf_wdata;
    end

    c7b_trace_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (trace_clear),
        .push  (push),
        .pop   (pop),
        .wdata ({seq_q, wb_rec}),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TR_RUN:    if (match_hit) state_d = TR_FROZEN;
            TR_FROZEN: state_d = TR_FROZEN;
            default:   state_d = TR_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || trace_clear) begin
            state_q    <= TR_RUN;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) seq_q <= seq_q + 1'b1;
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign {head_seq, head_rec} = head_raw;

    // Data is forced to zero when nothing is buffered so stale RAM never leaks out.
    assign tr.trace_valid = ~fifo_empty;
    assign tr.trace_pc    = tr.trace_valid ? head_rec.pc    : '0;
    assign tr.trace_wen   = tr.trace_valid & head_rec.wen;
    assign tr.trace_waddr = tr.trace_valid ? head_rec.waddr : '0;
    assign tr.trace_wdata = tr.trace_valid ? head_rec.wdata : '0;
    assign tr.trace_seq   = tr.trace_valid ? head_seq       : '0;

    assign trace_full   = (fifo_count == CNT_W'(DEPTH));
    assign trace_frozen = (state_q == TR_FROZEN);
    assign trace_ovf    = ovf_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/c7b_commit_trace.md
Name: c7b_commit_trace

Overview:
- Writer side of the core's retirement-observation interface.
- Captures every instruction retiring in the writeback stage: PC, GPR write port and a sequence number.
- Buffers records in a small FIFO and drains them to a debug/trace reader over a valid/ready handshake.
- Supports a PC-match freeze so a bench or debug host can stop capture at a known end-of-test PC (e.g. 0x1c000018) and inspect the tail of execution.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >=2.
- SEQ_W, 16, sequence-number width; wraps modulo 2^SEQ_W.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  an instruction retires this cycle
- wb_pc  in  32  PC of the retiring instruction
- wb_rf_wen  in  1  retiring instruction writes a GPR
- wb_rf_waddr  in  5  destination GPR index
- wb_rf_wdata  in  32  value written
- match_en  in  1  arm PC-match freeze
- match_pc  in  32  freeze PC
- trace_clear  in  1  one-cycle pulse: flush FIFO, clear flags/counters, return to RUN
- trace_valid  out  1  head record available
- trace_ready  in  1  reader accepts head record
- trace_pc  out  32  head record PC
- trace_wen  out  1  head record GPR-write flag
- trace_waddr  out  5  head record GPR index
- trace_wdata  out  32  head record write data
- trace_seq  out  SEQ_W  head record sequence number
- trace_full  out  1  FIFO holds DEPTH entries
- trace_frozen  out  1  capture stopped by PC match
- trace_ovf  out  1  sticky: at least one record dropped
- drop_cnt  out  16  dropped-record count; saturates at 0xFFFF

Behaviour:
- Reset (or trace_clear): FIFO empty; seq counter = 0; state = RUN. All outputs are 0: trace_valid, trace_full, trace_frozen, trace_ovf, drop_cnt, and all trace_* data.
- trace_clear has priority over every same-cycle push/pop.
- Record formation: trace_wen = wb_rf_wen & (wb_rf_waddr != 0). A write to r0 is recorded with wen = 0; waddr and wdata are still stored.
- Sequence numbering: each accepted record gets the current seq value; seq then increments, wrapping from 2^SEQ_W-1 to 0. Dropped records do not consume a seq value.
- Push: occurs when wb_valid, state RUN, and (not full, or a pop occurs this cycle).
- Drop: wb_valid in RUN while full with no same-cycle pop. Sets trace_ovf; increments drop_cnt (saturating).
- Pop: trace_valid & trace_ready. Data outputs hold stable while trace_valid & !trace_ready.
- Latency: a record pushed in cycle N is visible on trace_* in cycle N+1 at the earliest. There is no combinational bypass, including push and pop in the same cycle while empty.
- Count: full/empty come from the registered count. Simultaneous push+pop leaves count unchanged and is legal when full.
- State machine has two states:
  - RUN: capturing. If wb_valid & match_en & wb_pc == match_pc, the matching record is pushed under the normal rules (it can be dropped if full), then the state goes to FROZEN.
  - FROZEN: wb_valid is ignored (no push, no drop count). The FIFO keeps draining. trace_frozen = 1. Exits only on trace_clear or reset.
- match_en is sampled only in the cycle of the retire. Changing it while FROZEN has no effect.
- Reset mid-transfer: any record in flight is discarded; no partial state survives.

Decomposition:
- Shared package c7b_trace_pkg holds:
  - the record struct/width constants (PC_W=32, RADDR_W=5, DATA_W=32);
  - the state encoding (TR_RUN, TR_FROZEN);
  - DROP_W=16.
- One natural sub-module, c7b_trace_fifo: a generic synchronous FIFO (DEPTH x record width) with push/pop/full/empty/count. c7b_commit_trace adds record formation, seq numbering, drop logic and the freeze FSM around it.

Test Plan:
1. Basic capture: reset, then retire pc 0x1c000000 writing r5=0x5a, then pc 0x1c000004 writing r8=0x56, trace_ready=1 -> two records in order: seq 0 (pc 0x1c000000, wen 1, waddr 5, wdata 0x5a) and seq 1 (pc 0x1c000004, wen 1, waddr 8, wdata 0x56); each appears one cycle after its retire.
2. r0 write: retire with wen=1, waddr=0, wdata=0x1234 -> record has trace_wen=0, waddr 0, wdata 0x1234.
3. Overflow: trace_ready=0, 10 consecutive retires with DEPTH=8 -> trace_full=1 after the 8th; drop_cnt=2; trace_ovf=1. Draining yields seq 0..7; the next accepted retire gets seq 8.
4. Full with simultaneous push/pop: FIFO full, trace_ready=1 and wb_valid in the same cycle -> no drop, count stays 8, drop_cnt unchanged.
5. PC-match freeze: match_en=1, match_pc=0x1c000018; retire 0x1c000010, 0x1c000014, 0x1c000018, 0x1c00001c -> three records captured, trace_frozen=1 from the cycle after 0x1c000018, 0x1c00001c absent, drop_cnt=0. trace_clear then returns to RUN with seq=0.
6. Reset mid-operation: 3 records buffered and trace_valid=1, assert reset for one cycle -> next cycle trace_valid=0, drop_cnt=0, trace_ovf=0, trace_frozen=0; the next retire gets seq 0.
